// File: rtl/iram_port_arbiter_pkg.sv
// Shared constants for the IRAM port arbiter: FSM encodings and owner codes.
package iram_port_arbiter_pkg;

  typedef logic [1:0] arb_state_t;
  typedef logic       arb_owner_t;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_SHARED = 2'd1;
  localparam logic [1:0] ARB_LOCKED = 2'd2;

  localparam logic ARB_OWN_HOST = 1'b0;
  localparam logic ARB_OWN_XLT  = 1'b1;

endpackage

// File: rtl/iram_port_arbiter_if.sv
// Bus bundle for the IRAM port arbiter: host loader port, translator fetch
// port and the single-port IRAM macro interface.
// slave  = arbiter view, master = surrounding logic (host bridge, translator, RAM).
interface iram_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) ();

  logic              host_req;
  logic              host_we;
  logic              host_lock;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              xlt_req;
  logic [ADDR_W-1:0] xlt_addr;
  logic              xlt_gnt;
  logic              xlt_rvalid;
  logic [DATA_W-1:0] xlt_rdata;
  logic              xlt_waiting;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    input  xlt_req, xlt_addr,
    output xlt_gnt, xlt_rvalid, xlt_rdata, xlt_waiting,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output host_req, host_we, host_lock, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    output xlt_req, xlt_addr,
    input  xlt_gnt, xlt_rvalid, xlt_rdata, xlt_waiting,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/iram_port_arbiter_rr_pick.sv
// Two-way round-robin pick between host and translator requests.
// A lone requester always wins; on contention the side that did not own
// the port last wins.
module iram_rr_pick
  import iram_port_arbiter_pkg::*;
(
  input  logic       host_req,
  input  logic       xlt_req,
  input  arb_owner_t last_owner,
  output logic       pick_host,
  output logic       pick_xlt
);

  // Contention resolved against the previous owner
  always_comb begin
    pick_host = host_req & (~xlt_req  | (last_owner == ARB_OWN_XLT));
    pick_xlt  = xlt_req  & (~host_req | (last_owner == ARB_OWN_HOST));
  end

endmodule

// File: rtl/iram_port_arbiter.sv
// iram_port_arbiter: shares the single-port bytecode IRAM between the host
// loader and the JIT translator fetch front end. One grant per cycle, read
// data returned one cycle after the grant, xlt_waiting stalls the translator.
// Optional build macro: IRAM_ARB_STATS_EN adds stall / host-access counters.
module iram_port_arbiter
  import iram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  iram_port_arbiter_if.slave   bus
`ifdef IRAM_ARB_STATS_EN
  ,
  output logic [15:0]          stat_xlt_stall,
  output logic [15:0]          stat_host_acc
`endif
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_t       state, state_nxt;
  arb_owner_t       last_owner;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic             rr_host, rr_xlt;
  logic             host_gnt, xlt_gnt;
  logic             lock_full;
  logic             host_rvalid_q, xlt_rvalid_q;

  iram_rr_pick u_rr_pick (
    .host_req   (bus.host_req),
    .xlt_req    (bus.xlt_req),
    .last_owner (last_owner),
    .pick_host  (rr_host),
    .pick_xlt   (rr_xlt)
  );

  assign lock_full = (lock_cnt == CNT_W'(LOCK_MAX));

  // Grant selection; held off entirely while reset is asserted
  always_comb begin
    host_gnt = 1'b0;
    xlt_gnt  = 1'b0;
    if (reset) begin
      if (state == ARB_LOCKED) begin
        if (lock_full && bus.xlt_req) xlt_gnt  = 1'b1;
        else                          host_gnt = bus.host_req;
      end else begin
        host_gnt = rr_host;
        xlt_gnt  = rr_xlt;
      end
    end
  end

  // Next state and lock counter; IDLE arbitrates like SHARED, so a locked
  // host grant from IDLE enters LOCKED directly and counts as the first.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (host_gnt && bus.host_lock)          state_nxt = ARB_LOCKED;
        else if (bus.host_req || bus.xlt_req)   state_nxt = ARB_SHARED;
      end
      ARB_SHARED: begin
        if (host_gnt && bus.host_lock)          state_nxt = ARB_LOCKED;
        else if (!bus.host_req && !bus.xlt_req) state_nxt = ARB_IDLE;
      end
      ARB_LOCKED: begin
        if (!bus.host_lock)                     state_nxt = ARB_SHARED;
      end
      default:                                  state_nxt = ARB_IDLE;
    endcase

    lock_cnt_nxt = lock_cnt;
    if (state_nxt != ARB_LOCKED)      lock_cnt_nxt = '0;
    else if (xlt_gnt)                 lock_cnt_nxt = '0;
    else if (host_gnt && !lock_full)  lock_cnt_nxt = lock_cnt + 1'b1;
  end

  // Arbitration state, owner history and read-valid pipe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ARB_IDLE;
      last_owner    <= ARB_OWN_HOST;
      lock_cnt      <= '0;
      host_rvalid_q <= 1'b0;
      xlt_rvalid_q  <= 1'b0;
    end else begin
      state         <= state_nxt;
      lock_cnt      <= lock_cnt_nxt;
      if (host_gnt)     last_owner <= ARB_OWN_HOST;
      else if (xlt_gnt) last_owner <= ARB_OWN_XLT;
      host_rvalid_q <= host_gnt & ~bus.host_we;
      xlt_rvalid_q  <= xlt_gnt;
    end
  end

  // RAM port mux and requester-facing outputs
  always_comb begin
    bus.host_gnt    = host_gnt;
    bus.xlt_gnt     = xlt_gnt;
    bus.ram_en      = host_gnt | xlt_gnt;
    bus.ram_we      = host_gnt & bus.host_we;
    bus.ram_addr    = host_gnt ? bus.host_addr  : (xlt_gnt ? bus.xlt_addr : '0);
    bus.ram_wdata   = host_gnt ? bus.host_wdata : '0;
    bus.host_rvalid = host_rvalid_q;
    bus.xlt_rvalid  = xlt_rvalid_q;
    bus.host_rdata  = host_rvalid_q ? bus.ram_rdata : '0;
    bus.xlt_rdata   = xlt_rvalid_q  ? bus.ram_rdata : '0;
    bus.xlt_waiting = (bus.xlt_req & ~xlt_gnt) | ((state == ARB_LOCKED) & ~xlt_gnt);
  end

`ifdef IRAM_ARB_STATS_EN
  // Saturating stall-cycle and host-access counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_xlt_stall <= '0;
      stat_host_acc  <= '0;
    end else begin
      if (bus.xlt_waiting && stat_xlt_stall != '1) stat_xlt_stall <= stat_xlt_stall + 1'b1;
      if (host_gnt && stat_host_acc != '1)         stat_host_acc  <= stat_host_acc + 1'b1;
    end
  end
`endif

endmodule
